// File: rtl/z80_bus_arbiter_if.sv
// Bus interface between the Z80 machine-cycle sub-FSMs, the bus arbiter and the top-level pins.
interface z80_bus_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    done;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    sub_m1_L;
  logic [N_REQ-1:0]    sub_mreq_L;
  logic [N_REQ-1:0]    sub_iorq_L;
  logic [N_REQ-1:0]    sub_rd_L;
  logic [N_REQ-1:0]    sub_wr_L;
  logic [N_REQ-1:0]    sub_rfsh_L;
  logic [16*N_REQ-1:0] sub_addr;
  logic                M1_L;
  logic                MREQ_L;
  logic                IORQ_L;
  logic                RD_L;
  logic                WR_L;
  logic                RFSH_L;
  logic [15:0]         addr_out;
  logic                addr_oe;
  logic                BUSREQ_L;
  logic                BUSACK_L;
  logic                busy;

  // Requester / pin side.
  modport master (
    output req, done, sub_m1_L, sub_mreq_L, sub_iorq_L, sub_rd_L, sub_wr_L,
           sub_rfsh_L, sub_addr, BUSREQ_L,
    input  grant, M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, addr_out, addr_oe,
           BUSACK_L, busy
  );

  // Arbiter side.
  modport slave (
    input  req, done, sub_m1_L, sub_mreq_L, sub_iorq_L, sub_rd_L, sub_wr_L,
           sub_rfsh_L, sub_addr, BUSREQ_L,
    output grant, M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, addr_out, addr_oe,
           BUSACK_L, busy
  );
endinterface

// File: rtl/z80_bus_arbiter.sv
// Z80 external bus arbiter: fixed-priority machine-cycle ownership plus pin mux.
// Define Z80_BUSREQ_EN to enable the PARK state and BUSREQ_L/BUSACK_L handshake.
module z80_bus_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  z80_bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    PARK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busreq_w;
  logic             owner_done_w;
  logic [N_REQ-1:0] others_w;

`ifdef Z80_BUSREQ_EN
  assign busreq_w = ~bus.BUSREQ_L;
`else
  logic unused_busreq_l;
  assign unused_busreq_l = bus.BUSREQ_L;
  assign busreq_w        = 1'b0;
`endif

  function automatic logic [N_REQ-1:0] pick_lowest(input logic [N_REQ-1:0] v);
    logic [N_REQ-1:0] r;
    logic             found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // grant_q is one-hot in OWN, so masking done/req with it isolates the owner.
  assign owner_done_w = |(bus.done & grant_q);
  assign others_w     = bus.req & ~grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (busreq_w) begin
          state_d = PARK;
          grant_d = '0;
        end else if (|bus.req) begin
          state_d = OWN;
          grant_d = pick_lowest(bus.req);
        end
      end
      OWN: begin
        if (owner_done_w) begin
          if (busreq_w) begin
            state_d = PARK;
            grant_d = '0;
          end else if (|others_w) begin
            grant_d = pick_lowest(others_w);
          end else if (|(bus.req & grant_q)) begin
            grant_d = grant_q;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      PARK: begin
        grant_d = '0;
        if (!busreq_w) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    bus.M1_L     = 1'b1;
    bus.MREQ_L   = 1'b1;
    bus.IORQ_L   = 1'b1;
    bus.RD_L     = 1'b1;
    bus.WR_L     = 1'b1;
    bus.RFSH_L   = 1'b1;
    bus.addr_out = '0;
    bus.addr_oe  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        bus.M1_L     = bus.sub_m1_L[i];
        bus.MREQ_L   = bus.sub_mreq_L[i];
        bus.IORQ_L   = bus.sub_iorq_L[i];
        bus.RD_L     = bus.sub_rd_L[i];
        bus.WR_L     = bus.sub_wr_L[i];
        bus.RFSH_L   = bus.sub_rfsh_L[i];
        bus.addr_out = bus.sub_addr[16*i +: 16];
        bus.addr_oe  = 1'b1;
      end
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = (state_q != IDLE);

`ifdef Z80_BUSREQ_EN
  assign bus.BUSACK_L = (state_q != PARK);
`else
  assign bus.BUSACK_L = 1'b1;
`endif

endmodule

// File: doc/z80_bus_arbiter.md
# z80_bus_arbiter

Arbitrates the Z80 external bus among the control block's machine-cycle sub-FSMs (opcode fetch, memory read, memory write, I/O) and the external bus-request handshake. Grants the bus to exactly one owner per machine cycle, muxes that owner's strobes and address onto the top-level pins, and parks the bus with `BUSACK_L` asserted when an external master requests it at a machine-cycle boundary. Sits between the decoder/sub-FSMs and the `z80_top` pins, replacing ad-hoc per-FSM bus selects.

## Interface
- `N_REQ`, 4: number of sub-FSM requesters; index 0 has the highest priority.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N_REQ: level request per sub-FSM, held until granted.
- `done` in N_REQ: one-cycle pulse from an owner on its final T-state.
- `grant` out N_REQ: one-hot (or zero) registered bus ownership.
- `sub_m1_L`, `sub_mreq_L`, `sub_iorq_L`, `sub_rd_L`, `sub_wr_L`, `sub_rfsh_L` in N_REQ each: per-requester strobes.
- `sub_addr` in 16*N_REQ: per-requester address, requester i at bits [16i+15:16i].
- `M1_L`, `MREQ_L`, `IORQ_L`, `RD_L`, `WR_L`, `RFSH_L` out 1 each: top-level strobes.
- `addr_out` out 16: top-level address.
- `addr_oe` out 1: 1 when `addr_out` is driven by an owner.
- `BUSREQ_L` in 1: external bus request, active low.
- `BUSACK_L` out 1: external bus acknowledge, active low.
- `busy` out 1: 1 in OWN or PARK.

## Operation
- States: IDLE, OWN, PARK.
- IDLE: if `BUSREQ_L`=0 → PARK; else if any `req` → OWN, grant = lowest set index; else stay.
- OWN: grant held regardless of `req` changes. On `done[owner]`=1: if `BUSREQ_L`=0 → PARK; else if any `req` excluding the current owner's bit → OWN with the new winner (back-to-back, no idle cycle); else if `req[owner]`=1 → OWN with the same owner re-granted; else → IDLE.
- PARK: `BUSACK_L`=0, all strobes 1, `addr_oe`=0, `addr_out`=0, grant=0. Leave to IDLE the cycle after `BUSREQ_L` is sampled 1.
- Bus mux (combinational from registered `grant`): owner's strobes/address pass through; no owner → all strobes 1, `addr_out`=0, `addr_oe`=0.
- `done` bits from non-owners, and any `done` in IDLE/PARK, are ignored.
- `BUSREQ_L` is sampled only in IDLE or on the owner's `done` cycle; never pre-empts a machine cycle in progress.
- Fixed priority: index 0 (opcode fetch) beats all others. On `done`, the finishing owner yields to any other requester before being re-granted.

## Timing
- Reset: state IDLE, `grant`=0, all strobes 1, `BUSACK_L`=1, `addr_oe`=0, `addr_out`=0, `busy`=0; effective the cycle after `rst` is sampled high, including mid-OWN or mid-PARK.
- Grant latency: `req` seen in IDLE at cycle n → `grant` valid at n+1; the owner drives pins from n+1.
- Handover: `done` at cycle n → new grant at n+1, so consecutive machine cycles abut with zero gap.
- Park latency: `BUSREQ_L`=0 at boundary cycle n → `BUSACK_L`=0 at n+1; `BUSREQ_L`=1 at m → `BUSACK_L`=1 at m+1, next grant no earlier than m+2.
- `BUSREQ_L` and `req` both present at a boundary: PARK wins.

## Configuration
- `Z80_BUSREQ_EN` defined: PARK state and `BUSREQ_L`/`BUSACK_L` handshake as above.
- Not defined: `BUSREQ_L` ignored, `BUSACK_L` held at 1, PARK unreachable; the arbiter only cycles IDLE/OWN.

## Test plan
- Reset mid-OWN: grant req[1]; assert `rst` for one cycle → next cycle `grant`=0, all strobes 1, `BUSACK_L`=1, `addr_oe`=0.
- Priority: `req`=4'b0110 in IDLE → `grant`=4'b0010 next cycle; `addr_out` = requester 1's address 16'h1234, `MREQ_L` follows `sub_mreq_L[1]`.
- Back-to-back: owner 0 with `req`=4'b0101 held; pulse `done[0]` → next cycle `grant`=4'b0100 with no IDLE cycle; `done[2]` with `req`=0 → IDLE.
- Ignored done: owner 2; pulse `done[0]` and `done[1]` → `grant` stays 4'b0100.
- Bus request (macro on): owner 0, `BUSREQ_L`=0 mid-cycle → `BUSACK_L` stays 1 until `done[0]`, then 0 the next cycle with `addr_oe`=0; release `BUSREQ_L` → `BUSACK_L`=1 one cycle later, pending `req[3]` granted the cycle after.
- Macro off: `BUSREQ_L`=0 constantly with `req`=4'b0001 → `grant`=4'b0001, `BUSACK_L` never 0.
